// File: rtl/ntt_pass_scheduler_if.sv
// ntt_pass_scheduler_if: host handshake plus coefficient-RAM / twiddle-ROM bus
// of the NTT pass scheduler.
//   master modport : the scheduler (drives busy/done/result_bank and all
//                    read/write-back controls, samples start/do_scale/stall)
//   slave modport  : host FSM + butterfly array + RAM side
// Host side : start, do_scale, busy, done, result_bank
// RAM side  : stall, rd_en, rd_bank, rd_addr, w_idx, mode, swap,
//             wr_en, wr_bank, wr_addr
interface ntt_pass_scheduler_if #(
  parameter int ROWS     = 16,
  parameter int LUT_SIZE = 1360
);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int WIDX_W = $clog2(LUT_SIZE);

  logic              start;
  logic              do_scale;
  logic              stall;
  logic              busy;
  logic              done;
  logic              result_bank;
  logic              rd_en;
  logic              rd_bank;
  logic [ROW_W-1:0]  rd_addr;
  logic [WIDX_W-1:0] w_idx;
  logic              mode;
  logic              swap;
  logic              wr_en;
  logic              wr_bank;
  logic [ROW_W-1:0]  wr_addr;

  modport master (
    input  start, do_scale, stall,
    output busy, done, result_bank,
    output rd_en, rd_bank, rd_addr, w_idx, mode, swap,
    output wr_en, wr_bank, wr_addr
  );

  modport slave (
    output start, do_scale, stall,
    input  busy, done, result_bank,
    input  rd_en, rd_bank, rd_addr, w_idx, mode, swap,
    input  wr_en, wr_bank, wr_addr
  );
endinterface

// File: rtl/ntt_pass_scheduler.sv
// ntt_pass_scheduler: sequences the butterfly array through NUM_STAGES
// butterfly passes plus an optional multiply (scaling) pass. Each pass issues
// ROWS row reads, one per non-stalled cycle, ping-ponging between two
// coefficient banks; write-back controls are the read controls delayed by
// PIPE_LAT cycles and aimed at the opposite bank.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : ntt_pass_scheduler_if.master (see interface header)
module ntt_pass_scheduler #(
  parameter int ROWS       = 16,
  parameter int NUM_STAGES = 5,
  parameter int LUT_SIZE   = 1360,
  parameter int W_BASE     = 0,
  parameter int PIPE_LAT   = 6
) (
  input  logic clk,
  input  logic rst,
  ntt_pass_scheduler_if.master bus
);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int WIDX_W = $clog2(LUT_SIZE);
  localparam int PASS_W = $clog2(NUM_STAGES + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t            state_q, state_d;
  logic [PASS_W-1:0] pass_q;
  logic [PASS_W-1:0] npass_q;   // passes in this transform (P)
  logic [ROW_W-1:0]  row_q;
  logic [WIDX_W-1:0] widx_q;    // last issued twiddle index
  logic              res_q;
  logic              mode_q, swap_q;

  logic [PIPE_LAT-1:0] vld_p;
  logic [ROW_W-1:0]    addr_p [PIPE_LAT];
  logic                bank_p [PIPE_LAT];

  logic              issue;
  logic              last_row;
  logic              drained;
  logic              more_passes;
  logic              scale_pass;
  logic [PASS_W:0]   pass_inc;
  logic [WIDX_W-1:0] widx_now;

  assign issue       = (state_q == ISSUE) && !bus.stall;
  assign last_row    = (row_q == ROW_W'(ROWS - 1));
  // Only the final stage may still hold a write: it completes this cycle,
  // so the next pass can start reading next cycle without a RAW hazard.
  assign drained     = (vld_p[PIPE_LAT-2:0] == '0);
  assign pass_inc    = {1'b0, pass_q} + (PASS_W+1)'(1);
  assign more_passes = pass_inc < {1'b0, npass_q};
  assign scale_pass  = (pass_q == PASS_W'(NUM_STAGES));
  assign widx_now    = WIDX_W'(W_BASE + int'(pass_q) * ROWS + int'(row_q));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = ISSUE;
      ISSUE:   if (issue && last_row) state_d = DRAIN;
      DRAIN:   if (drained) state_d = more_passes ? ISSUE : FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pass_q  <= '0;
      npass_q <= '0;
      row_q   <= '0;
      widx_q  <= '0;
      res_q   <= 1'b0;
      mode_q  <= 1'b0;
      swap_q  <= 1'b0;
      vld_p   <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        addr_p[i] <= '0;
        bank_p[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        npass_q <= PASS_W'(NUM_STAGES) + PASS_W'(bus.do_scale);
        pass_q  <= '0;
        row_q   <= '0;
      end
      if (issue) begin
        row_q  <= last_row ? '0 : row_q + ROW_W'(1);
        widx_q <= widx_now;
      end
      if (state_q == DRAIN && drained && more_passes)
        pass_q <= pass_inc[PASS_W-1:0];
      if (state_q == FINISH)
        res_q <= npass_q[0];
      // issue -> p0: mode/swap lag rd_en by one cycle to meet RAM/ROM data
      mode_q <= issue && scale_pass;
      swap_q <= issue && scale_pass;
      // p0 .. p(PIPE_LAT-1): write-back delay line
      vld_p     <= {vld_p[PIPE_LAT-2:0], issue};
      addr_p[0] <= row_q;
      bank_p[0] <= ~pass_q[0];
      for (int i = 1; i < PIPE_LAT; i++) begin
        addr_p[i] <= addr_p[i-1];
        bank_p[i] <= bank_p[i-1];
      end
    end
  end

  // The largest twiddle index must fit the ROM; there is no wrap in hardware.
  always_ff @(posedge clk) begin
    if (!rst)
      assert (W_BASE + (NUM_STAGES + 1) * ROWS <= LUT_SIZE)
        else $error("twiddle index range exceeds LUT_SIZE");
  end

  assign bus.busy        = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done        = (state_q == FINISH);
  assign bus.result_bank = (state_q == FINISH) ? npass_q[0] : res_q;
  assign bus.rd_en       = issue;
  assign bus.rd_bank     = pass_q[0];
  assign bus.rd_addr     = row_q;
  assign bus.w_idx       = issue ? widx_now : widx_q;
  assign bus.mode        = mode_q;
  assign bus.swap        = swap_q;
  assign bus.wr_en       = vld_p[PIPE_LAT-1];
  assign bus.wr_addr     = addr_p[PIPE_LAT-1];
  assign bus.wr_bank     = bank_p[PIPE_LAT-1];
endmodule
